// File: rtl/wb_pkg.sv
// Shared types for the writeback queue: queue entry layout and default depth.
// No logic; imported by the queue, its storage and the interface users.
package wb_pkg;
    localparam int WBQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// Writeback queue bus: LSU/ALU request ports, register-file write port, read ports.
// slave = queue side, master = core side driving requests and reads.
interface wb_queue_if;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    modport slave (
        input  lsu_valid, lsu_rd, lsu_data, alu_valid, alu_rd, alu_data,
        input  a1, a2, rf_rd1, rf_rd2,
        output lsu_ready, alu_ready, we3, a3, wd3, rd1, rd2
    );

    modport master (
        output lsu_valid, lsu_rd, lsu_data, alu_valid, alu_rd, alu_data,
        output a1, a2, rf_rd1, rf_rd2,
        input  lsu_ready, alu_ready, we3, a3, wd3, rd1, rd2
    );
endinterface

// File: rtl/wbq_fifo.sv
// Circular entry store with two ordered write slots and one read slot, plus occupancy count.
// Latency: write visible at head next cycle; no backpressure, caller guarantees free slots.
// With WBQ_BYPASS_EN the raw storage and read pointer are exported for bypass search.
module wbq_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = WBQ_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_wr0,
    input  wb_entry_t              i_wr0_dat,
    input  logic                   i_wr1,
    input  wb_entry_t              i_wr1_dat,
    input  logic                   i_pop,
`ifdef WBQ_BYPASS_EN
    output wb_entry_t [DEPTH-1:0]  o_mem,
    output logic [AW-1:0]          o_rptr,
`endif
    output wb_entry_t              o_head,
    output logic [AW:0]            o_count
);
    wb_entry_t [DEPTH-1:0] r_mem;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic [AW-1:0]         w_wptr1;

    assign w_wptr1 = r_wptr + AW'(1);

    // Slot 0 is always the older of a simultaneous pair.
    always_ff @(posedge clk) begin
        if (i_wr0) r_mem[r_wptr] <= i_wr0_dat;
        if (i_wr1) r_mem[i_wr0 ? w_wptr1 : r_wptr] <= i_wr1_dat;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_wr0) + AW'(i_wr1);
            if (i_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_wr0) + (AW+1)'(i_wr1) - (AW+1)'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
`ifdef WBQ_BYPASS_EN
    assign o_mem   = r_mem;
    assign o_rptr  = r_rptr;
`endif
endmodule

// File: rtl/wb_queue.sv
// Writeback queue: merges LSU/ALU results into the RF write port, head retires every cycle.
// Latency: accepted entry reaches we3 no earlier than next cycle; ready from free-slot count only.
// Define WBQ_BYPASS_EN to forward queued data onto rd1/rd2.
module wb_queue
    import wb_pkg::*;
#(
    parameter  int DEPTH = WBQ_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset_n,
    wb_queue_if.slave wb
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic        w_pop;
    logic        w_wr0;
    logic        w_wr1;
    logic [AW:0] w_count;
    logic [AW:0] w_free;
    wb_entry_t   w_head;
    wb_entry_t   w_lsu_ent;
    wb_entry_t   w_alu_ent;

    // Gated by reset so an in-flight head is never written while resetting.
    assign w_pop  = reset_n && (w_count != '0);
    assign w_free = DEPTH_W - w_count + {{AW{1'b0}}, w_pop};

    assign wb.lsu_ready = reset_n && ((wb.lsu_rd == 5'd0) || (w_free >= (AW+1)'(1)));
    assign wb.alu_ready = reset_n && ((wb.alu_rd == 5'd0) || (w_free >= (AW+1)'(2)));

    assign w_wr0 = wb.lsu_valid && wb.lsu_ready && (wb.lsu_rd != 5'd0);
    assign w_wr1 = wb.alu_valid && wb.alu_ready && (wb.alu_rd != 5'd0);

    assign w_lsu_ent = '{rd: wb.lsu_rd, data: wb.lsu_data};
    assign w_alu_ent = '{rd: wb.alu_rd, data: wb.alu_data};

`ifdef WBQ_BYPASS_EN
    wb_entry_t [DEPTH-1:0] w_mem;
    logic [AW-1:0]         w_rptr;
    logic [AW-1:0]         w_idx;
    logic [31:0]           w_byp1;
    logic [31:0]           w_byp2;
`endif

    wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr0     (w_wr0),
        .i_wr0_dat (w_lsu_ent),
        .i_wr1     (w_wr1),
        .i_wr1_dat (w_alu_ent),
        .i_pop     (w_pop),
`ifdef WBQ_BYPASS_EN
        .o_mem     (w_mem),
        .o_rptr    (w_rptr),
`endif
        .o_head    (w_head),
        .o_count   (w_count)
    );

    assign wb.we3 = w_pop;
    assign wb.a3  = w_pop ? w_head.rd   : 5'd0;
    assign wb.wd3 = w_pop ? w_head.data : 32'd0;

`ifdef WBQ_BYPASS_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        w_byp1 = wb.rf_rd1;
        w_byp2 = wb.rf_rd2;
        w_idx  = w_rptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = w_rptr + AW'(i);
            if ((AW+1)'(i) < w_count) begin
                if (w_mem[w_idx].rd == wb.a1) w_byp1 = w_mem[w_idx].data;
                if (w_mem[w_idx].rd == wb.a2) w_byp2 = w_mem[w_idx].data;
            end
        end
    end

    assign wb.rd1 = (wb.a1 == 5'd0) ? 32'd0 : w_byp1;
    assign wb.rd2 = (wb.a2 == 5'd0) ? 32'd0 : w_byp2;
`else
    assign wb.rd1 = (wb.a1 == 5'd0) ? 32'd0 : wb.rf_rd1;
    assign wb.rd2 = (wb.a2 == 5'd0) ? 32'd0 : wb.rf_rd2;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model compared every cycle, plus literal scenarios.
module tb_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wb_queue_if wbif();

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (wbif)
    );

    int n_chk = 0;
    int n_fail = 0;
    wb_entry_t mq[$];
    bit m_lsu_acc;
    bit m_alu_acc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int free_slots();
        int n;
        n = mq.size();
        return DEPTH - n + ((n != 0) ? 1 : 0);
    endfunction

    function automatic logic exp_lsu_ready();
        return reset_n && ((wbif.lsu_rd == 5'd0) || (free_slots() >= 1));
    endfunction

    function automatic logic exp_alu_ready();
        return reset_n && ((wbif.alu_rd == 5'd0) || (free_slots() >= 2));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
`ifdef WBQ_BYPASS_EN
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == a) return mq[i].data;
`endif
        return rf;
    endfunction

    // Compare DUT against the model at the falling edge, latch acceptance decisions.
    task automatic at_neg();
        logic wr;
        @(negedge clk);
        wr = reset_n && (mq.size() != 0);
        check("we3", wbif.we3, wr);
        check("a3", wbif.a3, wr ? mq[0].rd : 5'd0);
        check("wd3", wbif.wd3, wr ? mq[0].data : 32'd0);
        check("lsu_ready", wbif.lsu_ready, exp_lsu_ready());
        check("alu_ready", wbif.alu_ready, exp_alu_ready());
        check("rd1", wbif.rd1, exp_rd(wbif.a1, wbif.rf_rd1));
        check("rd2", wbif.rd2, exp_rd(wbif.a2, wbif.rf_rd2));
        m_lsu_acc = wbif.lsu_valid && exp_lsu_ready() && (wbif.lsu_rd != 5'd0);
        m_alu_acc = wbif.alu_valid && exp_alu_ready() && (wbif.alu_rd != 5'd0);
    endtask

    task automatic end_cyc();
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (m_lsu_acc) mq.push_back({wbif.lsu_rd, wbif.lsu_data});
            if (m_alu_acc) mq.push_back({wbif.alu_rd, wbif.alu_data});
        end
        #1;
    endtask

    task automatic idle();
        wbif.lsu_valid = 1'b0; wbif.lsu_rd = 5'd0; wbif.lsu_data = 32'd0;
        wbif.alu_valid = 1'b0; wbif.alu_rd = 5'd0; wbif.alu_data = 32'd0;
        wbif.a1 = 5'd0; wbif.a2 = 5'd0; wbif.rf_rd1 = 32'd0; wbif.rf_rd2 = 32'd0;
    endtask

    task automatic set_lsu(input logic [4:0] r, input logic [31:0] d);
        wbif.lsu_valid = 1'b1; wbif.lsu_rd = r; wbif.lsu_data = d;
    endtask

    task automatic set_alu(input logic [4:0] r, input logic [31:0] d);
        wbif.alu_valid = 1'b1; wbif.alu_rd = r; wbif.alu_data = d;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) begin at_neg(); end_cyc(); end
    endtask

    initial begin
        idle();
        // Requests during reset must be refused and discarded.
        reset_n = 1'b0;
        set_lsu(5'd6, 32'h66); set_alu(5'd8, 32'h88);
        at_neg();
        check("rst_lsu_ready", wbif.lsu_ready, 1'b0);
        check("rst_alu_ready", wbif.alu_ready, 1'b0);
        end_cyc();
        at_neg(); end_cyc();
        reset_n = 1'b1; idle();
        at_neg();
        check("post_rst_we3", wbif.we3, 1'b0);
        check("post_rst_a3", wbif.a3, 5'd0);
        check("post_rst_wd3", wbif.wd3, 32'd0);
        end_cyc();

        // Single ALU writeback retires next cycle for exactly one cycle.
        set_alu(5'd5, 32'hDEADBEEF);
        at_neg(); check("single_alu_ready", wbif.alu_ready, 1'b1); end_cyc();
        idle();
        at_neg();
        check("single_we3", wbif.we3, 1'b1);
        check("single_a3", wbif.a3, 5'd5);
        check("single_wd3", wbif.wd3, 32'hDEADBEEF);
        end_cyc();
        at_neg(); check("single_we3_gone", wbif.we3, 1'b0); end_cyc();

        // Simultaneous pair: LSU retires before ALU.
        set_lsu(5'd3, 32'h11); set_alu(5'd4, 32'h22);
        at_neg();
        check("pair_lsu_ready", wbif.lsu_ready, 1'b1);
        check("pair_alu_ready", wbif.alu_ready, 1'b1);
        end_cyc();
        idle();
        at_neg(); check("pair_first_a3", wbif.a3, 5'd3); check("pair_first_wd3", wbif.wd3, 32'h11); end_cyc();
        at_neg(); check("pair_second_a3", wbif.a3, 5'd4); check("pair_second_wd3", wbif.wd3, 32'h22); end_cyc();
        at_neg(); check("pair_done_we3", wbif.we3, 1'b0); end_cyc();

        // Fill: occupancy 0 -> 2 -> 3 -> 4, then only one slot is free.
        repeat (3) begin
            set_lsu(5'd1, $urandom); set_alu(5'd2, $urandom);
            at_neg(); end_cyc();
        end
        at_neg();
        check("full_lsu_ready", wbif.lsu_ready, 1'b1);
        check("full_alu_ready", wbif.alu_ready, 1'b0);
        end_cyc();
        drain(5);

        // Two writes to r7; youngest wins, in-flight writes are not forwarded.
        set_lsu(5'd7, 32'h1); set_alu(5'd7, 32'h2);
        wbif.a1 = 5'd7; wbif.rf_rd1 = 32'h0; wbif.a2 = 5'd0; wbif.rf_rd2 = 32'h55;
        at_neg();
        check("byp_inflight_rd1", wbif.rd1, 32'h0);
        check("byp_zero_rd2", wbif.rd2, 32'h0);
        end_cyc();
        idle();
        wbif.a1 = 5'd7; wbif.rf_rd1 = 32'h0;
        at_neg();
`ifdef WBQ_BYPASS_EN
        check("byp_youngest_rd1", wbif.rd1, 32'h2);
`else
        check("nobyp_rd1", wbif.rd1, 32'h0);
`endif
        end_cyc();
        drain(3);

        // rd=0 request accepted and dropped.
        set_alu(5'd0, 32'hFF);
        at_neg(); check("r0_alu_ready", wbif.alu_ready, 1'b1); end_cyc();
        idle();
        at_neg(); check("r0_we3", wbif.we3, 1'b0); end_cyc();
        at_neg(); check("r0_we3_later", wbif.we3, 1'b0); end_cyc();

        // Reset with three entries queued: nothing reaches the write port.
        repeat (2) begin
            set_lsu(5'd9, 32'hA); set_alu(5'd10, 32'hB);
            at_neg(); end_cyc();
        end
        idle(); reset_n = 1'b0;
        at_neg(); check("midrst_we3", wbif.we3, 1'b0); end_cyc();
        reset_n = 1'b1;
        repeat (4) begin
            at_neg();
            check("after_rst_we3", wbif.we3, 1'b0);
            check("after_rst_a3", wbif.a3, 5'd0);
            check("after_rst_wd3", wbif.wd3, 32'd0);
            end_cyc();
        end

        // Randomized traffic with small register range to hit r0 and bypass matches.
        repeat (3000) begin
            reset_n = ($urandom_range(0, 199) != 0);
            wbif.lsu_valid = ($urandom_range(0, 9) < 7);
            wbif.lsu_rd    = 5'($urandom_range(0, 7));
            wbif.lsu_data  = $urandom;
            wbif.alu_valid = ($urandom_range(0, 9) < 7);
            wbif.alu_rd    = 5'($urandom_range(0, 7));
            wbif.alu_data  = $urandom;
            wbif.a1        = 5'($urandom_range(0, 7));
            wbif.a2        = 5'($urandom_range(0, 7));
            wbif.rf_rd1    = $urandom;
            wbif.rf_rd2    = $urandom;
            at_neg(); end_cyc();
        end
        reset_n = 1'b1;
        drain(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
